// File: rtl/latency_data_memory.sv
// Data memory with fixed request-to-ready latencies, byte-lane sub-word access and request edge detection.
// Define LATENCY_JITTER_EN to add 0..7 pseudo-random extra cycles to every latency load.
module latency_data_memory #(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 64,
  parameter int DEPTH      = 1024,
  parameter int READ_LAT   = 4,
  parameter int WRITE_LAT  = 4,
  parameter int FINISH_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              read_request,
  input  logic              write_request,
  input  logic [ADDR_W-1:0] address,
  input  logic [1:0]        block_size,
  input  logic [DATA_W-1:0] write_data,
  output logic              read_ready,
  output logic              write_ready,
  output logic              write_finished,
  output logic [DATA_W-1:0] read_data,
  output logic              busy,
  output logic              protocol_error
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] RD_LOAD  = CNT_W'(READ_LAT - 1);
  localparam logic [CNT_W-1:0] WR_LOAD  = CNT_W'(WRITE_LAT - 1);
  localparam logic [CNT_W-1:0] FIN_LOAD = CNT_W'(FINISH_LAT - 1);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, WR_FIN} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rdReq_q, wrReq_q;
  logic [IDX_W-1:0]   idx_q;
  logic [2:0]         lane_q;
  logic [1:0]         size_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  readData_q;
  logic               readReady_q, writeReady_q, writeFinished_q, protErr_q;
  logic               readDone, wrReadyD, wrFinD, protErrD, capture;
  logic               rdStart, wrStart;
  logic [CNT_W-1:0]   jitter;
  logic [DATA_W-1:0]  mem [DEPTH];
  logic [DATA_W-1:0]  shifted, extract, wdataShifted;
  logic [7:0]         byteMask, byteEn;
  logic               unusedAddrBits;

  assign rdStart        = read_request & ~rdReq_q;
  assign wrStart        = write_request & ~wrReq_q;
  assign unusedAddrBits = ^address[ADDR_W-1:IDX_W+3];

`ifdef LATENCY_JITTER_EN
  logic [15:0] lfsr_q;

  // Fibonacci LFSR for x^16+x^14+x^13+x^11+1, free-running from reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= 16'hACE1;
    else        lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  assign jitter = {{(CNT_W-3){1'b0}}, lfsr_q[2:0]};
`else
  assign jitter = '0;
`endif

  // Sub-word accesses are forced onto their natural alignment inside the word
  function automatic logic [2:0] alignLane(logic [2:0] off, logic [1:0] sz);
    case (sz)
      2'd0:    return off;
      2'd1:    return {off[2:1], 1'b0};
      2'd2:    return {off[2], 2'b00};
      default: return 3'b000;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    capture  = 1'b0;
    readDone = 1'b0;
    wrReadyD = 1'b0;
    wrFinD   = 1'b0;
    protErrD = 1'b0;
    case (state_q)
      IDLE: begin
        if (rdStart && wrStart) begin
          protErrD = 1'b1;
        end else if (rdStart) begin
          state_d = RD_WAIT;
          cnt_d   = RD_LOAD + jitter;
          capture = 1'b1;
        end else if (wrStart) begin
          state_d = WR_WAIT;
          cnt_d   = WR_LOAD + jitter;
          capture = 1'b1;
        end
      end
      RD_WAIT: begin
        protErrD = rdStart | wrStart;
        if (cnt_q == '0) begin
          readDone = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WR_WAIT: begin
        protErrD = rdStart | wrStart;
        if (cnt_q == '0) begin
          wrReadyD = 1'b1;
          cnt_d    = FIN_LOAD + jitter;
          state_d  = WR_FIN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WR_FIN: begin
        protErrD = rdStart | wrStart;
        if (cnt_q == '0) begin
          wrFinD  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    shifted = mem[idx_q] >> {lane_q, 3'b000};
    case (size_q)
      2'd0:    extract = DATA_W'(shifted[7:0]);
      2'd1:    extract = DATA_W'(shifted[15:0]);
      2'd2:    extract = DATA_W'(shifted[31:0]);
      default: extract = shifted;
    endcase
    case (size_q)
      2'd0:    byteMask = 8'h01;
      2'd1:    byteMask = 8'h03;
      2'd2:    byteMask = 8'h0F;
      default: byteMask = 8'hFF;
    endcase
    byteEn       = byteMask << lane_q;
    wdataShifted = wdata_q << {lane_q, 3'b000};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      rdReq_q         <= 1'b0;
      wrReq_q         <= 1'b0;
      idx_q           <= '0;
      lane_q          <= '0;
      size_q          <= '0;
      wdata_q         <= '0;
      readData_q      <= '0;
      readReady_q     <= 1'b0;
      writeReady_q    <= 1'b0;
      writeFinished_q <= 1'b0;
      protErr_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      rdReq_q         <= read_request;
      wrReq_q         <= write_request;
      readReady_q     <= readDone;
      writeReady_q    <= wrReadyD;
      writeFinished_q <= wrFinD;
      protErr_q       <= protErrD;
      if (capture) begin
        idx_q   <= address[IDX_W+2:3];
        lane_q  <= alignLane(address[2:0], block_size);
        size_q  <= block_size;
        wdata_q <= write_data;
      end
      if (readDone) readData_q <= extract;
    end
  end

  // Storage is only touched on the commit cycle, so a reset before it leaves contents intact
  always_ff @(posedge clk) begin
    if (wrFinD) begin
      for (int b = 0; b < 8; b++) begin
        if (byteEn[b]) mem[idx_q][8*b +: 8] <= wdataShifted[8*b +: 8];
      end
    end
  end

  assign read_ready     = readReady_q;
  assign write_ready    = writeReady_q;
  assign write_finished = writeFinished_q;
  assign read_data      = readData_q;
  assign protocol_error = protErr_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_latency_data_memory.sv
// Scoreboard bench for latency_data_memory: byte-level reference memory, queued expectations, pulse monitor.
`timescale 1ns/1ps
module tb_latency_data_memory;

  localparam int DATA_W     = 64;
  localparam int ADDR_W     = 64;
  localparam int DEPTH      = 1024;
  localparam int READ_LAT   = 4;
  localparam int WRITE_LAT  = 4;
  localparam int FINISH_LAT = 2;
  localparam int MEMB       = DEPTH * 8;
`ifdef LATENCY_JITTER_EN
  localparam int JIT = 7;
`else
  localparam int JIT = 0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              read_request = 1'b0;
  logic              write_request = 1'b0;
  logic [ADDR_W-1:0] address = '0;
  logic [1:0]        block_size = '0;
  logic [DATA_W-1:0] write_data = '0;
  logic              read_ready, write_ready, write_finished, busy, protocol_error;
  logic [DATA_W-1:0] read_data;

  latency_data_memory #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
    .READ_LAT(READ_LAT), .WRITE_LAT(WRITE_LAT), .FINISH_LAT(FINISH_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .read_request(read_request), .write_request(write_request),
    .address(address), .block_size(block_size), .write_data(write_data),
    .read_ready(read_ready), .write_ready(write_ready), .write_finished(write_finished),
    .read_data(read_data), .busy(busy), .protocol_error(protocol_error)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    logic [63:0] data;
    int          start;
  } rdExp_t;

  rdExp_t     readQ[$];
  int         wrReadyQ[$];
  int         wrFinQ[$];
  int         perrQ[$];
  int         lastWrReady = 0;
  int         checks = 0;
  int         failures = 0;
  logic [7:0] refMem [MEMB];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  task automatic checkRange(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic flagUnexpected(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s: pulse seen, expected none", name);
  endtask

  function automatic logic [63:0] modelRead(input logic [63:0] a, input logic [1:0] s);
    int nb = 1 << s;
    int base = int'(a % 64'(MEMB));
    logic [63:0] v = '0;
    base = base - (base % nb);
    for (int i = 0; i < nb; i++) v[8*i +: 8] = refMem[base + i];
    return v;
  endfunction

  task automatic modelWrite(input logic [63:0] a, input logic [1:0] s, input logic [63:0] d);
    int nb = 1 << s;
    int base = int'(a % 64'(MEMB));
    base = base - (base % nb);
    for (int i = 0; i < nb; i++) refMem[base + i] = d[8*i +: 8];
  endtask

  // Monitor: every output pulse consumes one expectation from its queue
  rdExp_t monRd;
  int     monInt;
  always @(negedge clk) begin
    if (rst_n) begin
      if (protocol_error) begin
        if (perrQ.size() == 0) flagUnexpected("protocol_error");
        else begin
          monInt = perrQ.pop_front();
          checkRange("perrCycle", cycle, monInt, monInt);
        end
      end
      if (read_ready) begin
        if (readQ.size() == 0) flagUnexpected("read_ready");
        else begin
          monRd = readQ.pop_front();
          checkOutput("readData", read_data, monRd.data);
          checkRange("readLatency", cycle - monRd.start, READ_LAT, READ_LAT + JIT);
        end
      end
      if (write_ready) begin
        if (wrReadyQ.size() == 0) flagUnexpected("write_ready");
        else begin
          monInt = wrReadyQ.pop_front();
          checkRange("writeReadyLatency", cycle - monInt, WRITE_LAT, WRITE_LAT + JIT);
          lastWrReady = cycle;
        end
      end
      if (write_finished) begin
        if (wrFinQ.size() == 0) flagUnexpected("write_finished");
        else begin
          monInt = wrFinQ.pop_front();
          checkRange("writeFinishLatency", cycle - lastWrReady, FINISH_LAT, FINISH_LAT + JIT);
        end
      end
    end
  end

  task automatic waitIdle();
    int n = 0;
    while (busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      failures++;
      $display("[TB] FAIL waitIdle: busy=1 after 60 cycles, expected 0");
    end
  endtask

  // Issue one request pulse at the current negedge; expectations are queued before the DUT can answer
  task automatic applyStimulus(input bit isWrite, input logic [63:0] a, input logic [1:0] s,
                               input logic [63:0] d, input bit updateModel);
    rdExp_t e;
    address    = a;
    block_size = s;
    write_data = d;
    if (isWrite) begin
      write_request = 1'b1;
      wrReadyQ.push_back(cycle + 1);
      wrFinQ.push_back(cycle + 1);
      if (updateModel) modelWrite(a, s, d);
    end else begin
      read_request = 1'b1;
      e.data  = modelRead(a, s);
      e.start = cycle + 1;
      readQ.push_back(e);
    end
    @(negedge clk);
    read_request  = 1'b0;
    write_request = 1'b0;
    @(negedge clk);
  endtask

  task automatic doOp(input bit isWrite, input logic [63:0] a, input logic [1:0] s, input logic [63:0] d);
    waitIdle();
    applyStimulus(isWrite, a, s, d, 1'b1);
    waitIdle();
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [63:0] a;
    repeat (3) @(negedge clk);
    checkOutput("resetPulses", {59'b0, read_ready, write_ready, write_finished, busy, protocol_error}, 64'd0);
    checkOutput("resetReadData", read_data, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 16; i++) doOp(1'b1, 64'(i * 8), 2'd3, {$urandom(), $urandom()});

    doOp(1'b1, 64'h40, 2'd3, 64'h1122334455667788);
    doOp(1'b0, 64'h40, 2'd3, '0);
    doOp(1'b1, 64'h43, 2'd0, 64'hAB);
    doOp(1'b0, 64'h40, 2'd3, '0);
    doOp(1'b0, 64'h42, 2'd1, '0);
    doOp(1'b0, 64'h40 + 64'(MEMB), 2'd3, '0);

    // Simultaneous read and write starts are both refused
    read_request  = 1'b1;
    write_request = 1'b1;
    perrQ.push_back(cycle + 1);
    @(negedge clk);
    checkOutput("busyAfterDualStart", {63'b0, busy}, 64'd0);
    read_request  = 1'b0;
    write_request = 1'b0;
    repeat (3) @(negedge clk);

    // A second read start while one is in flight is dropped
    applyStimulus(1'b0, 64'h40, 2'd3, '0, 1'b0);
    address       = 64'h48;
    read_request  = 1'b1;
    perrQ.push_back(cycle + 1);
    @(negedge clk);
    read_request  = 1'b0;
    waitIdle();
    repeat (2) @(negedge clk);

    // Reset during WR_WAIT aborts the write and leaves storage untouched
    applyStimulus(1'b1, 64'h40, 2'd3, 64'hDEADBEEFCAFEF00D, 1'b0);
    rst_n = 1'b0;
    wrReadyQ.delete();
    wrFinQ.delete();
    @(negedge clk);
    checkOutput("midResetPulses", {59'b0, read_ready, write_ready, write_finished, busy, protocol_error}, 64'd0);
    checkOutput("midResetReadData", read_data, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    doOp(1'b0, 64'h40, 2'd3, '0);

    for (int n = 0; n < 120; n++) begin
      a = {$urandom(), 32'h0} | 64'($urandom_range(3, 0) * MEMB + $urandom_range(15, 0) * 8 + $urandom_range(7, 0));
      doOp(1'($urandom_range(1, 0)), a, 2'($urandom_range(3, 0)), {$urandom(), $urandom()});
    end

    repeat (10) @(negedge clk);
    checkOutput("readQEmpty", 64'(readQ.size()), 64'd0);
    checkOutput("wrReadyQEmpty", 64'(wrReadyQ.size()), 64'd0);
    checkOutput("wrFinQEmpty", 64'(wrFinQ.size()), 64'd0);
    checkOutput("perrQEmpty", 64'(perrQ.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
